// File: rtl/riscv_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// riscv_multicycle_ctrl
//
// Multi-cycle control FSM for the RV32I single core. It steps each instruction
// through FETCH -> DECODE -> EXECUTE -> (MEM) -> (WB) and drives every datapath
// enable and select from the current state and the instruction register fields.
//
// Supported subset: LUI, JAL, JALR, BEQ, LW, SW, ADDI, ADD, SUB, AND.
// Anything else traps, with a sticky `illegal` flag.
//
// Optional feature macro: RISCV_CTRL_PERF_EN
//   defined   : cycle_cnt and instret_cnt are free-running counters.
//   undefined : both ports read 0 and no counter flops exist.
//
// Parameters
//   MEM_WAIT_MAX : max cycles mem_req may wait for mem_ready (0 = unlimited)
//   CNT_WIDTH    : performance counter width
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   opcode/funct3/funct7  IR fields, valid from DECODE onward
//   alu_zero              ALU result == 0 (branch compare)
//   mem_ready             memory completes the current access this cycle
//   ir_we, pc_we, pc_sel  IR load, PC update, PC source (00 +4, 01 +imm, 10 ALU&~1)
//   mem_req/we/addr_sel   memory request, write, address source (0 PC, 1 ALU)
//   alu_op/src_a/src_b    ALU operation and operand selects
//   reg_we, wb_sel        register write, writeback source (00 ALU, 01 mem, 10 PC+4)
//   retire                one-cycle pulse per completed instruction
//   illegal, bus_err      sticky trap causes
//   state_o               current FSM state (debug)
//   cycle_cnt/instret_cnt performance counters
//
// Handshake: the memory access is a request/complete pair. mem_req is held
// high in FETCH or MEM until the cycle in which mem_ready is sampled high;
// that same cycle completes the access. mem_ready in any other state is ignored.
// -----------------------------------------------------------------------------
module riscv_multicycle_ctrl #(
  parameter int MEM_WAIT_MAX = 0,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic                 alu_zero,
  input  logic                 mem_ready,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic [1:0]           pc_sel,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 mem_addr_sel,
  output logic [2:0]           alu_op,
  output logic                 alu_src_a,
  output logic                 alu_src_b,
  output logic                 reg_we,
  output logic [1:0]           wb_sel,
  output logic                 retire,
  output logic                 illegal,
  output logic                 bus_err,
  output logic [2:0]           state_o,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] instret_cnt
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SLT  = 3'd5,
    ALU_PASS = 3'd6
  } alu_op_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_R      = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_JALR = 3'b000;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   bus_err_q, bus_err_d;
  logic   in_mem;
  logic   timeout;

  // ---------------------------------------------------------------------------
  // Instruction decode
  // ---------------------------------------------------------------------------
  logic is_lui, is_jal, is_jalr, is_beq, is_lw, is_sw, is_addi;
  logic is_add, is_sub, is_and, is_legal;

  assign is_lui   = (opcode == OP_LUI);
  assign is_jal   = (opcode == OP_JAL);
  assign is_jalr  = (opcode == OP_JALR)   && (funct3 == F3_JALR);
  assign is_beq   = (opcode == OP_BRANCH) && (funct3 == F3_BEQ);
  assign is_lw    = (opcode == OP_LOAD)   && (funct3 == F3_LW);
  assign is_sw    = (opcode == OP_STORE)  && (funct3 == F3_SW);
  assign is_addi  = (opcode == OP_IMM)    && (funct3 == F3_ADDI);
  assign is_add   = (opcode == OP_R) && (funct3 == F3_ADD) && (funct7 == F7_BASE);
  assign is_sub   = (opcode == OP_R) && (funct3 == F3_ADD) && (funct7 == F7_SUB);
  assign is_and   = (opcode == OP_R) && (funct3 == F3_AND) && (funct7 == F7_BASE);
  assign is_legal = is_lui | is_jal | is_jalr | is_beq | is_lw | is_sw |
                    is_addi | is_add | is_sub | is_and;

  assign in_mem = (state_q == S_FETCH) || (state_q == S_MEM);

  // ---------------------------------------------------------------------------
  // Memory wait timeout. wait_q counts the stalled cycles of the current
  // access; it is 0 on the first mem_req cycle, so a stall on the
  // MEM_WAIT_MAX-th cycle is the timeout and a completion on it is a success.
  // ---------------------------------------------------------------------------
  generate
    if (MEM_WAIT_MAX > 0) begin : g_wait
      localparam int WAIT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
      localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

      logic [WAIT_W-1:0] wait_q, wait_d;

      assign wait_d  = (in_mem && !mem_ready) ? wait_q + 1'b1 : '0;
      assign timeout = in_mem && !mem_ready && (wait_q == WAIT_LAST);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_q <= '0;
        else        wait_q <= wait_d;
      end
    end else begin : g_no_wait
      assign timeout = 1'b0;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    illegal_d    = illegal_q;
    bus_err_d    = bus_err_q;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 2'b00;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    alu_op       = ALU_ADD;
    alu_src_a    = 1'b0;
    alu_src_b    = 1'b0;
    reg_we       = 1'b0;
    wb_sel       = 2'b00;
    retire       = 1'b0;

    // ALU controls stay valid through MEM and WB so the address and the
    // writeback result remain stable until they are consumed.
    if (state_q == S_EXECUTE || state_q == S_MEM || state_q == S_WB) begin
      if (is_sub || is_beq) begin
        alu_op = ALU_SUB;
      end else if (is_and) begin
        alu_op = ALU_AND;
      end else if (is_lui) begin
        alu_op    = ALU_PASS;
        alu_src_b = 1'b1;
      end else if (is_addi || is_lw || is_sw || is_jalr) begin
        alu_src_b = 1'b1;
      end
    end

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          bus_err_d = 1'b1;
          state_d   = S_TRAP;
        end
      end

      S_DECODE: begin
        if (is_legal) begin
          state_d = S_EXECUTE;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_TRAP;
        end
      end

      S_EXECUTE: begin
        if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else if (is_beq) begin
          pc_we   = 1'b1;
          pc_sel  = alu_zero ? 2'b01 : 2'b00;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (is_jal) begin
          pc_we   = 1'b1;
          pc_sel  = 2'b01;
          reg_we  = 1'b1;
          wb_sel  = 2'b10;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (is_jalr) begin
          pc_we   = 1'b1;
          pc_sel  = 2'b10;
          reg_we  = 1'b1;
          wb_sel  = 2'b10;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_sw;
        if (mem_ready) begin
          if (is_sw) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout) begin
          bus_err_d = 1'b1;
          state_d   = S_TRAP;
        end
      end

      S_WB: begin
        reg_we  = 1'b1;
        wb_sel  = is_lw ? 2'b01 : 2'b00;
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end

      S_TRAP: begin
        state_d = S_TRAP;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Reset must drop an in-flight request at once, not at the next edge,
    // since FETCH (the reset state) would otherwise assert mem_req.
    if (!rst_n) begin
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_sel       = 2'b00;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      alu_op       = ALU_ADD;
      alu_src_b    = 1'b0;
      reg_we       = 1'b0;
      wb_sel       = 2'b00;
      retire       = 1'b0;
    end
  end

  assign illegal = illegal_q;
  assign bus_err = bus_err_q;
  assign state_o = state_q;

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef RISCV_CTRL_PERF_EN
  logic [CNT_WIDTH-1:0] cycle_cnt_q, instret_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      if (state_q != S_TRAP) cycle_cnt_q   <= cycle_cnt_q + 1'b1;
      if (retire)            instret_cnt_q <= instret_cnt_q + 1'b1;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for riscv_multicycle_ctrl (built with MEM_WAIT_MAX = 4).
// Each table row is one clock cycle: inputs are driven on the falling edge,
// all outputs are compared 1 ns later against a hand-derived expected word.
// A row with rst = 1 holds rst_n low for that cycle.
// -----------------------------------------------------------------------------
module tb_riscv_multicycle_ctrl;

  localparam int CNT_WIDTH = 32;

  // expected-word field values
  localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_T = 3'd5;
  localparam logic [2:0] A_ADD = 3'd0, A_SUB = 3'd1, A_AND = 3'd2, A_PASS = 3'd6;

  localparam logic [6:0] OP_LUI = 7'b0110111, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR  = 7'b1100011, OP_LD  = 7'b0000011, OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_IMM = 7'b0010011, OP_R   = 7'b0110011, OP_SYS  = 7'b1110011;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic       alu_zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic ir_we, pc_we, mem_req, mem_we, mem_addr_sel, alu_src_a, alu_src_b;
  logic reg_we, retire, illegal, bus_err;
  logic [1:0] pc_sel, wb_sel;
  logic [2:0] alu_op, state_o;
  logic [CNT_WIDTH-1:0] cycle_cnt, instret_cnt;

  riscv_multicycle_ctrl #(.MEM_WAIT_MAX(4), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .alu_zero(alu_zero), .mem_ready(mem_ready),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .reg_we(reg_we), .wb_sel(wb_sel), .retire(retire),
    .illegal(illegal), .bus_err(bus_err), .state_o(state_o),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  logic [20:0] act;
  assign act = {state_o, ir_we, pc_we, pc_sel, mem_req, mem_we, mem_addr_sel,
                alu_op, alu_src_a, alu_src_b, reg_we, wb_sel, retire, illegal, bus_err};

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        z;
    logic        rdy;
    logic [20:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [20:0] exp_q[$];
  int          n_vec  = 0;
  int          n_miss = 0;

  logic [20:0] E_RST, E_FETCH, E_FWAIT, E_DEC, E_ILL, E_BERR, E_MEMX, E_LDST_EX;

  function automatic logic [20:0] e(
    input logic [2:0] st, input logic ir, input logic pcw, input logic [1:0] ps,
    input logic mr, input logic mw, input logic as, input logic [2:0] ao,
    input logic sa, input logic sb, input logic rw, input logic [1:0] ws,
    input logic rt, input logic il, input logic be);
    return {st, ir, pcw, ps, mr, mw, as, ao, sa, sb, rw, ws, rt, il, be};
  endfunction

  // driver tasks
  task automatic add(input logic r, input logic [6:0] op, input logic [2:0] f3,
                     input logic [6:0] f7, input logic z, input logic rdy,
                     input logic [20:0] ex);
    vec_t v;
    v.rst = r; v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.rdy = rdy; v.exp = ex;
    tbl.push_back(v);
  endtask

  // FETCH completing at once, then DECODE
  task automatic fd(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    add(0, op, f3, f7, 0, 1, E_FETCH);
    add(0, op, f3, f7, 0, 1, E_DEC);
  endtask

  task automatic check(input string what, input logic [CNT_WIDTH-1:0] got,
                       input logic [CNT_WIDTH-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", what, got, want);
    end
  endtask

  initial begin
    int retires;
    logic [CNT_WIDTH-1:0] exp_cyc, exp_ins;

    E_RST     = e(S_F, 0, 0, 2'b00, 0, 0, 0, A_ADD, 0, 0, 0, 2'b00, 0, 0, 0);
    E_FETCH   = e(S_F, 1, 0, 2'b00, 1, 0, 0, A_ADD, 0, 0, 0, 2'b00, 0, 0, 0);
    E_FWAIT   = e(S_F, 0, 0, 2'b00, 1, 0, 0, A_ADD, 0, 0, 0, 2'b00, 0, 0, 0);
    E_DEC     = e(S_D, 0, 0, 2'b00, 0, 0, 0, A_ADD, 0, 0, 0, 2'b00, 0, 0, 0);
    E_ILL     = e(S_T, 0, 0, 2'b00, 0, 0, 0, A_ADD, 0, 0, 0, 2'b00, 0, 1, 0);
    E_BERR    = e(S_T, 0, 0, 2'b00, 0, 0, 0, A_ADD, 0, 0, 0, 2'b00, 0, 0, 1);
    E_LDST_EX = e(S_E, 0, 0, 2'b00, 0, 0, 0, A_ADD, 0, 1, 0, 2'b00, 0, 0, 0);
    E_MEMX    = e(S_M, 0, 0, 2'b00, 1, 0, 1, A_ADD, 0, 1, 0, 2'b00, 0, 0, 0);

    // reset (mem_ready high must not leak through)
    add(1, OP_R, 3'd0, 7'h00, 0, 1, E_RST);
    // ADD: 4 cycles, retire in WB
    fd(OP_R, 3'd0, 7'h00);
    add(0, OP_R, 3'd0, 7'h00, 0, 1, e(S_E, 0, 0, 2'b00, 0, 0, 0, A_ADD, 0, 0, 0, 2'b00, 0, 0, 0));
    add(0, OP_R, 3'd0, 7'h00, 0, 1, e(S_W, 0, 1, 2'b00, 0, 0, 0, A_ADD, 0, 0, 1, 2'b00, 1, 0, 0));
    // SUB
    fd(OP_R, 3'd0, 7'h20);
    add(0, OP_R, 3'd0, 7'h20, 0, 1, e(S_E, 0, 0, 2'b00, 0, 0, 0, A_SUB, 0, 0, 0, 2'b00, 0, 0, 0));
    add(0, OP_R, 3'd0, 7'h20, 0, 1, e(S_W, 0, 1, 2'b00, 0, 0, 0, A_SUB, 0, 0, 1, 2'b00, 1, 0, 0));
    // AND
    fd(OP_R, 3'd7, 7'h00);
    add(0, OP_R, 3'd7, 7'h00, 0, 1, e(S_E, 0, 0, 2'b00, 0, 0, 0, A_AND, 0, 0, 0, 2'b00, 0, 0, 0));
    add(0, OP_R, 3'd7, 7'h00, 0, 1, e(S_W, 0, 1, 2'b00, 0, 0, 0, A_AND, 0, 0, 1, 2'b00, 1, 0, 0));
    // ADDI with one FETCH stall
    add(0, OP_IMM, 3'd0, 7'h00, 0, 0, E_FWAIT);
    fd(OP_IMM, 3'd0, 7'h00);
    add(0, OP_IMM, 3'd0, 7'h00, 0, 1, e(S_E, 0, 0, 2'b00, 0, 0, 0, A_ADD, 0, 1, 0, 2'b00, 0, 0, 0));
    add(0, OP_IMM, 3'd0, 7'h00, 0, 1, e(S_W, 0, 1, 2'b00, 0, 0, 0, A_ADD, 0, 1, 1, 2'b00, 1, 0, 0));
    // LUI
    fd(OP_LUI, 3'd3, 7'h55);
    add(0, OP_LUI, 3'd3, 7'h55, 0, 1, e(S_E, 0, 0, 2'b00, 0, 0, 0, A_PASS, 0, 1, 0, 2'b00, 0, 0, 0));
    add(0, OP_LUI, 3'd3, 7'h55, 0, 1, e(S_W, 0, 1, 2'b00, 0, 0, 0, A_PASS, 0, 1, 1, 2'b00, 1, 0, 0));
    // BEQ taken, then not taken: 3 cycles each, no register write
    fd(OP_BR, 3'd0, 7'h00);
    add(0, OP_BR, 3'd0, 7'h00, 1, 1, e(S_E, 0, 1, 2'b01, 0, 0, 0, A_SUB, 0, 0, 0, 2'b00, 1, 0, 0));
    fd(OP_BR, 3'd0, 7'h00);
    add(0, OP_BR, 3'd0, 7'h00, 0, 1, e(S_E, 0, 1, 2'b00, 0, 0, 0, A_SUB, 0, 0, 0, 2'b00, 1, 0, 0));
    // JAL, JALR
    fd(OP_JAL, 3'd5, 7'h12);
    add(0, OP_JAL, 3'd5, 7'h12, 0, 1, e(S_E, 0, 1, 2'b01, 0, 0, 0, A_ADD, 0, 0, 1, 2'b10, 1, 0, 0));
    fd(OP_JALR, 3'd0, 7'h00);
    add(0, OP_JALR, 3'd0, 7'h00, 0, 1, e(S_E, 0, 1, 2'b10, 0, 0, 0, A_ADD, 0, 1, 1, 2'b10, 1, 0, 0));
    // LW: mem_ready ignored in EXECUTE, 3 stall cycles in MEM, completes on the 4th
    fd(OP_LD, 3'd2, 7'h00);
    add(0, OP_LD, 3'd2, 7'h00, 0, 1, E_LDST_EX);
    add(0, OP_LD, 3'd2, 7'h00, 0, 0, E_MEMX);
    add(0, OP_LD, 3'd2, 7'h00, 0, 0, E_MEMX);
    add(0, OP_LD, 3'd2, 7'h00, 0, 0, E_MEMX);
    add(0, OP_LD, 3'd2, 7'h00, 0, 1, E_MEMX);
    add(0, OP_LD, 3'd2, 7'h00, 0, 0, e(S_W, 0, 1, 2'b00, 0, 0, 0, A_ADD, 0, 1, 1, 2'b01, 1, 0, 0));
    // SW: retires in MEM, no WB
    fd(OP_ST, 3'd2, 7'h00);
    add(0, OP_ST, 3'd2, 7'h00, 0, 0, E_LDST_EX);
    add(0, OP_ST, 3'd2, 7'h00, 0, 1, e(S_M, 0, 1, 2'b00, 1, 1, 1, A_ADD, 0, 1, 0, 2'b00, 1, 0, 0));
    add(0, OP_ST, 3'd2, 7'h00, 0, 0, E_FWAIT);
    // SYSTEM opcode traps and stays
    fd(OP_SYS, 3'd0, 7'h00);
    add(0, OP_SYS, 3'd0, 7'h00, 0, 1, E_ILL);
    add(0, OP_SYS, 3'd0, 7'h00, 1, 0, E_ILL);
    add(0, OP_SYS, 3'd0, 7'h00, 0, 1, E_ILL);
    // R-type with unsupported funct7, and LB
    add(1, OP_R, 3'd0, 7'h01, 0, 1, E_RST);
    fd(OP_R, 3'd0, 7'h01);
    add(0, OP_R, 3'd0, 7'h01, 0, 1, E_ILL);
    add(1, OP_LD, 3'd0, 7'h00, 0, 1, E_RST);
    fd(OP_LD, 3'd0, 7'h00);
    add(0, OP_LD, 3'd0, 7'h00, 0, 1, E_ILL);
    // FETCH timeout after 4 stalled cycles
    add(1, OP_R, 3'd0, 7'h00, 0, 0, E_RST);
    for (int k = 0; k < 4; k++) add(0, OP_R, 3'd0, 7'h00, 0, 0, E_FWAIT);
    add(0, OP_R, 3'd0, 7'h00, 0, 1, E_BERR);
    add(0, OP_R, 3'd0, 7'h00, 0, 1, E_BERR);
    // reset asserted mid-FETCH drops mem_req before the next edge
    add(1, OP_R, 3'd0, 7'h00, 0, 0, E_RST);
    add(0, OP_R, 3'd0, 7'h00, 0, 0, E_FWAIT);
    add(0, OP_R, 3'd0, 7'h00, 0, 0, E_FWAIT);
    add(1, OP_R, 3'd0, 7'h00, 0, 0, E_RST);
    // reset asserted mid-MEM
    fd(OP_LD, 3'd2, 7'h00);
    add(0, OP_LD, 3'd2, 7'h00, 0, 0, E_LDST_EX);
    add(0, OP_LD, 3'd2, 7'h00, 0, 0, E_MEMX);
    add(0, OP_LD, 3'd2, 7'h00, 0, 0, E_MEMX);
    add(1, OP_LD, 3'd2, 7'h00, 0, 0, E_RST);
    // MEM timeout after 4 stalled cycles
    fd(OP_LD, 3'd2, 7'h00);
    add(0, OP_LD, 3'd2, 7'h00, 0, 0, E_LDST_EX);
    for (int k = 0; k < 4; k++) add(0, OP_LD, 3'd2, 7'h00, 0, 0, E_MEMX);
    add(0, OP_LD, 3'd2, 7'h00, 0, 1, E_BERR);

    // apply table
    for (int i = 0; i < tbl.size(); i++) begin
      logic [20:0] ex;
      @(negedge clk);
      rst_n     = !tbl[i].rst;
      opcode    = tbl[i].op;
      funct3    = tbl[i].f3;
      funct7    = tbl[i].f7;
      alu_zero  = tbl[i].z;
      mem_ready = tbl[i].rdy;
      exp_q.push_back(tbl[i].exp);
      #1;
      ex = exp_q.pop_front();
      n_vec++;
      if (act !== ex) begin
        n_miss++;
        $display("FAIL vec %0d (op %b f3 %0d): got %h, expected %h", i, tbl[i].op, tbl[i].f3, act, ex);
      end
    end

    // 10 back-to-back ADDIs at zero wait: 40 cycles, 10 retires
    @(negedge clk);
    rst_n = 1'b0;
    opcode = OP_IMM; funct3 = 3'd0; funct7 = 7'h00; alu_zero = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    retires = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (retire) retires++;
      @(negedge clk);
    end
    #1;
`ifdef RISCV_CTRL_PERF_EN
    exp_cyc = 40;
    exp_ins = 10;
`else
    exp_cyc = 0;
    exp_ins = 0;
`endif
    check("retire_pulses", CNT_WIDTH'(retires), 10);
    check("cycle_cnt", cycle_cnt, exp_cyc);
    check("instret_cnt", instret_cnt, exp_ins);
    check("state_after_10_addi", CNT_WIDTH'(state_o), CNT_WIDTH'(S_F));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
